// File: rtl/i2s_sync_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_sync_capture: oversampled multi-mic I2S receiver, CLK domain |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module i2s_sync_capture #(
  parameter int NUM_CH      = 4,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ENABLE,
  input  logic                            AUD_BCLK,
  input  logic                            AUD_ADCLRCK,
  input  logic [NUM_CH-1:0]               GPIO_DIN,
  output logic [NUM_CH*2*DATA_BITS-1:0]   SAMPLE_DATA,
  output logic                            SAMPLE_VALID,
  input  logic                            SAMPLE_READY,
  output logic                            OVERRUN,
  output logic                            SHORT_FRAME,
  input  logic                            CLEAR_FLAGS
);

  localparam int SW    = NUM_CH + 2;
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_t;

  logic [SW-1:0]           sync_q [SYNC_STAGES];
  logic                    bclk_s, ws_s, bclk_d, ws_prev;
  logic [NUM_CH-1:0]       sd_s;
  logic                    bclk_rise, ws_fall, ws_rise;
  state_t                  state, next_state;
  logic                    in_left, in_right, slot_end, commit_now, commit_pend;
  logic                    take, short_slot;
  logic [CNT_W-1:0]        bit_cnt, cnt_next, align_sh;
  logic [NUM_CH*2*DATA_BITS-1:0] frame_bus;

  // BCLK, WS and SD share one chain so their relative timing is preserved
  assign {bclk_s, ws_s, sd_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      bclk_d  <= 1'b0;
      ws_prev <= 1'b0;
    end else begin
      sync_q[0] <= {AUD_BCLK, AUD_ADCLRCK, GPIO_DIN};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      bclk_d <= bclk_s;
      if (bclk_rise) ws_prev <= ws_s;
    end
  end

  assign bclk_rise = bclk_s & ~bclk_d;
  assign ws_fall   = bclk_rise & ws_prev & ~ws_s;
  assign ws_rise   = bclk_rise & ~ws_prev & ws_s;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // The WS-change edge carries the outgoing slot's last bit, so it is
  // consumed by that slot and the next edge is the new slot's MSB.
  always_comb begin
    next_state = state;
    in_left    = 1'b0;
    in_right   = 1'b0;
    slot_end   = 1'b0;
    commit_now = 1'b0;
    case (state)
      IDLE:  if (ENABLE) next_state = ALIGN;
      ALIGN: if (ws_fall) next_state = LEFT;
      LEFT: begin
        in_left = 1'b1;
        if (ws_rise) begin
          slot_end   = 1'b1;
          next_state = RIGHT;
        end
      end
      RIGHT: begin
        in_right = 1'b1;
        if (ws_fall) begin
          slot_end   = 1'b1;
          commit_now = 1'b1;
          next_state = ENABLE ? LEFT : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign take       = bclk_rise & (in_left | in_right) & (bit_cnt < FULL_CNT);
  assign cnt_next   = bit_cnt + CNT_W'(take);
  assign short_slot = slot_end & (cnt_next < FULL_CNT);
  assign align_sh   = FULL_CNT - cnt_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt     <= '0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= commit_now;
      if (slot_end || !(in_left || in_right)) bit_cnt <= '0;
      else if (take)                          bit_cnt <= cnt_next;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_BITS-1:0] left_sh, right_sh, left_nx, right_nx;

    // Short slots are MSB-aligned, pushing stale bits out the top
    always_comb begin
      left_nx  = left_sh;
      right_nx = right_sh;
      if (take && in_left)        left_nx  = (left_sh << 1)  | DATA_BITS'(sd_s[i]);
      if (take && in_right)       right_nx = (right_sh << 1) | DATA_BITS'(sd_s[i]);
      if (short_slot && in_left)  left_nx  = left_nx << align_sh;
      if (short_slot && in_right) right_nx = right_nx << align_sh;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        left_sh  <= '0;
        right_sh <= '0;
      end else begin
        left_sh  <= left_nx;
        right_sh <= right_nx;
      end
    end

    assign frame_bus[(i+1)*2*DATA_BITS-1 -: 2*DATA_BITS] = {left_sh, right_sh};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SAMPLE_DATA  <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
      SHORT_FRAME  <= 1'b0;
    end else begin
      if (commit_pend && (!SAMPLE_VALID || SAMPLE_READY)) begin
        SAMPLE_DATA  <= frame_bus;
        SAMPLE_VALID <= 1'b1;
      end else if (SAMPLE_VALID && SAMPLE_READY) begin
        SAMPLE_VALID <= 1'b0;
      end

      if (commit_pend && SAMPLE_VALID && !SAMPLE_READY) OVERRUN <= 1'b1;
      else if (CLEAR_FLAGS)                             OVERRUN <= 1'b0;

      if (short_slot)       SHORT_FRAME <= 1'b1;
      else if (CLEAR_FLAGS) SHORT_FRAME <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_sync_capture.sv
`default_nettype none
// tb_i2s_sync_capture: drives I2S master frames and checks captured frames
// against a slot-level model (first DATA_BITS transmitted bits, zero padded).
module tb_i2s_sync_capture;

  localparam int NCH  = 4;
  localparam int DB   = 16;
  localparam int SS   = 2;
  localparam int HALF = 163;
  localparam int FW   = NCH * 2 * DB;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           ENABLE = 1'b1;
  logic           AUD_BCLK = 1'b0;
  logic           AUD_ADCLRCK = 1'b0;
  logic [NCH-1:0] GPIO_DIN = '0;
  logic [FW-1:0]  SAMPLE_DATA;
  logic           SAMPLE_VALID;
  logic           SAMPLE_READY = 1'b1;
  logic           OVERRUN;
  logic           SHORT_FRAME;
  logic           CLEAR_FLAGS = 1'b0;

  int             checks = 0;
  int             errors = 0;
  int             handshakes = 0;
  logic           prev_hs = 1'b0;
  logic [FW-1:0]  exp_q[$];
  logic [31:0]    cur_l[NCH];
  logic [31:0]    cur_r[NCH];
  logic [NCH-1:0] prev_sd = '0;
  logic           closed = 1'b0;
  logic [FW-1:0]  f1_exp;

  i2s_sync_capture #(
    .NUM_CH(NCH),
    .DATA_BITS(DB),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .GPIO_DIN(GPIO_DIN),
    .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .OVERRUN(OVERRUN),
    .SHORT_FRAME(SHORT_FRAME),
    .CLEAR_FLAGS(CLEAR_FLAGS)
  );

  always #10 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected field = first DB bits sent in the slot; words hold only the sent bits
  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f = '0;
    for (int c = 0; c < NCH; c++)
      f[c*2*DB +: 2*DB] = {cur_l[c][31 -: DB], cur_r[c][31 -: DB]};
    return f;
  endfunction

  task automatic rand_words(input int n);
    for (int c = 0; c < NCH; c++) begin
      cur_l[c] = $urandom() & (32'hFFFF_FFFF << (32 - n));
      cur_r[c] = $urandom() & (32'hFFFF_FFFF << (32 - n));
    end
  endtask

  // One BCLK period: WS and delayed data change while BCLK is low
  task automatic emit(input logic ws, input logic [NCH-1:0] sd);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = ws;
    GPIO_DIN    = prev_sd;
    prev_sd     = sd;
    #HALF;
    AUD_BCLK = 1'b1;
    #HALF;
  endtask

  // Frame of n-bit slots; the trailing WS-low period carries the last right bit
  // and doubles as period 0 of the following frame.
  task automatic send_frame(input int n);
    for (int p = 0; p < 2 * n; p++) begin
      logic [NCH-1:0] b;
      for (int c = 0; c < NCH; c++)
        b[c] = (p < n) ? cur_l[c][31 - p] : cur_r[c][31 - (p - n)];
      if (p == 0 && closed) prev_sd = b;
      else emit((p < n) ? 1'b0 : 1'b1, b);
    end
    emit(1'b0, '0);
    closed = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (prev_hs) check("valid_pulse", FW'(SAMPLE_VALID), FW'(1'b0));
    prev_hs <= SAMPLE_VALID && SAMPLE_READY;
    if (SAMPLE_VALID && SAMPLE_READY) begin
      handshakes <= handshakes + 1;
      check("frame_expected", FW'(exp_q.size() > 0), FW'(1'b1));
      if (exp_q.size() > 0) check("frame_data", SAMPLE_DATA, exp_q.pop_front());
    end
  end

  initial begin
    int hs_mark;

    repeat (5) @(negedge CLK);
    check("rst_valid", FW'(SAMPLE_VALID), FW'(1'b0));
    check("rst_data", SAMPLE_DATA, '0);
    check("rst_overrun", FW'(OVERRUN), FW'(1'b0));
    check("rst_short", FW'(SHORT_FRAME), FW'(1'b0));

    // Reset released mid-frame while WS=1: partial frame discarded
    rand_words(32);
    fork
      send_frame(32);
      begin
        #(2 * HALF * 48);
        @(posedge CLK); #2 RESET = 1'b0;
      end
    join

    // First whole frame after alignment
    for (int c = 0; c < NCH; c++) begin cur_l[c] = '0; cur_r[c] = '0; end
    cur_l[0] = 32'hA5C3_0000; cur_r[0] = 32'h1234_0000;
    cur_l[3] = 32'h8001_0000; cur_r[3] = 32'h7FFE_0000;
    exp_q.push_back(model_frame());
    send_frame(32);
    check("t1_mic1", FW'(SAMPLE_DATA[31:0]), FW'(32'hA5C3_1234));
    check("t1_mic4", FW'(SAMPLE_DATA[127:96]), FW'(32'h8001_7FFE));
    check("t1_overrun", FW'(OVERRUN), FW'(1'b0));
    check("t1_short", FW'(SHORT_FRAME), FW'(1'b0));

    for (int k = 0; k < 3; k++) begin
      rand_words(32);
      exp_q.push_back(model_frame());
      send_frame(32);
    end

    // Back-pressure: F1 held, F2/F3 dropped
    @(posedge CLK); #2 SAMPLE_READY = 1'b0;
    rand_words(32);
    f1_exp = model_frame();
    send_frame(32);
    check("t3_overrun_f1", FW'(OVERRUN), FW'(1'b0));
    rand_words(32);
    send_frame(32);
    check("t3_overrun_f2", FW'(OVERRUN), FW'(1'b1));
    rand_words(32);
    send_frame(32);
    check("t3_valid_held", FW'(SAMPLE_VALID), FW'(1'b1));
    check("t3_data_held", SAMPLE_DATA, f1_exp);
    exp_q.push_back(f1_exp);
    @(posedge CLK); #2 SAMPLE_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check("t3_valid_clear", FW'(SAMPLE_VALID), FW'(1'b0));
    @(posedge CLK); #2 CLEAR_FLAGS = 1'b1;
    @(posedge CLK); #2 CLEAR_FLAGS = 1'b0;
    @(negedge CLK);
    check("t3_overrun_clr", FW'(OVERRUN), FW'(1'b0));
    check("t4_short_pre", FW'(SHORT_FRAME), FW'(1'b0));

    // 12-bit slots into 16-bit fields
    rand_words(12);
    cur_l[0] = 32'hABC0_0000;
    exp_q.push_back(model_frame());
    send_frame(12);
    check("t4_left_field", FW'(SAMPLE_DATA[31:16]), FW'(16'hABC0));
    check("t4_short", FW'(SHORT_FRAME), FW'(1'b1));
    check("t4_overrun", FW'(OVERRUN), FW'(1'b0));

    // ENABLE dropped during LEFT of frame N: N still committed, then silence
    rand_words(32);
    exp_q.push_back(model_frame());
    fork
      send_frame(32);
      begin
        #(2 * HALF * 8);
        @(posedge CLK); #2 ENABLE = 1'b0;
      end
    join
    hs_mark = handshakes;
    rand_words(32);
    send_frame(32);
    check("t5_no_valid", FW'(handshakes - hs_mark), FW'(0));
    @(posedge CLK); #2 ENABLE = 1'b1;
    rand_words(32);
    send_frame(32);
    rand_words(32);
    exp_q.push_back(model_frame());
    send_frame(32);

    // One-cycle reset during RIGHT slot
    rand_words(32);
    fork
      send_frame(32);
      begin
        #(2 * HALF * 45);
        @(posedge CLK); #2 RESET = 1'b1;
        @(posedge CLK); #2 RESET = 1'b0;
        @(negedge CLK);
        check("t6_valid", FW'(SAMPLE_VALID), FW'(1'b0));
        check("t6_data", SAMPLE_DATA, '0);
        check("t6_overrun", FW'(OVERRUN), FW'(1'b0));
        check("t6_short", FW'(SHORT_FRAME), FW'(1'b0));
      end
    join
    rand_words(32);
    exp_q.push_back(model_frame());
    send_frame(32);

    repeat (10) @(negedge CLK);
    check("queue_drained", FW'(exp_q.size()), FW'(0));
    check("handshake_count", FW'(handshakes), FW'(9));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_sync_capture.md
Name: i2s_sync_capture

Overview:
- Multi-channel I2S receiver that runs entirely in the CLK domain and feeds the microphone DMA/streaming stage.
- Oversamples AUD_BCLK, AUD_ADCLRCK and NUM_CH serial data lines, and deserialises one left/right sample pair per microphone.
- Presents each completed stereo frame for all mics on a one-deep valid/ready output register.
- Replaces the per-mic BCLK-domain receivers, so no data crosses clock domains downstream.

Parameters:
- NUM_CH, 4, number of microphone data lines.
- DATA_BITS, 16, bits captured per channel slot, MSB-first (1..32).
- SYNC_STAGES, 2, synchroniser flops on BCLK, WS and SD (>=2).

Ports:
- CLK  in  1  system clock; must be >= 4x AUD_BCLK.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  capture enable; sampled at frame boundaries only.
- AUD_BCLK  in  1  I2S bit clock (asynchronous).
- AUD_ADCLRCK  in  1  I2S word select; 0 = left slot, 1 = right slot.
- GPIO_DIN  in  NUM_CH  serial data, bit i = mic i+1.
- SAMPLE_DATA  out  NUM_CH*2*DATA_BITS  mic i occupies bits [(i+1)*2*DATA_BITS-1 : i*2*DATA_BITS], packed {left,right}.
- SAMPLE_VALID  out  1  frame held in the output register.
- SAMPLE_READY  in  1  consumer accepts the frame when VALID && READY.
- OVERRUN  out  1  sticky: a frame was dropped because the output register was full.
- SHORT_FRAME  out  1  sticky: a slot ended with fewer than DATA_BITS bits.
- CLEAR_FLAGS  in  1  single-cycle pulse; clears OVERRUN and SHORT_FRAME.

Behaviour:

Synchronisation and edge detection:
- BCLK, WS and all SD bits pass through SYNC_STAGES flops of identical depth, so they stay mutually aligned.
- bclk_rise is asserted for one CLK when synchronised BCLK = 1 and its registered copy = 0.
- On each bclk_rise, sample ws_s and sd_s, then update ws_prev <= ws_s.
- ws_fall = bclk_rise && ws_prev==1 && ws_s==0. ws_rise is defined analogously.

FSM states: IDLE, ALIGN, LEFT, RIGHT.
- IDLE: entered on reset. Moves to ALIGN when ENABLE==1.
- ALIGN: discards bits. Moves to LEFT on ws_fall, which guarantees the first captured frame is whole.
- LEFT:
  - I2S one-bit delay: the bclk_rise that produces ws_fall carries the last right bit. The first left MSB is the next bclk_rise. A skip flag handles this.
  - Each later bclk_rise shifts sd_s[i] into left_sh[i] and increments bit_cnt, while bit_cnt < DATA_BITS. Further bits are ignored.
  - On ws_rise: if bit_cnt < DATA_BITS, left-shift the remainder to MSB-align with zero LSBs and set SHORT_FRAME. Then reset bit_cnt and skip, and go to RIGHT.
- RIGHT: same shifting into right_sh.
  - On ws_fall: apply the same short-slot handling, then commit the frame.
  - If ENABLE==0, go to IDLE; otherwise go to LEFT with skip armed.
- ENABLE deassertion mid-frame takes effect only at the RIGHT->(IDLE/LEFT) boundary. The frame in progress completes and is committed.

Commit and output handshake:
- The commit cycle is the cycle after the CLK cycle of the terminating ws_fall.
- If SAMPLE_VALID==0, or SAMPLE_READY==1 in that cycle, load SAMPLE_DATA and set SAMPLE_VALID=1.
- Otherwise drop the new frame, keep the old one, and set OVERRUN.
- SAMPLE_VALID clears on VALID && READY unless a commit occurs in the same cycle; commit wins.
- SAMPLE_DATA is stable while VALID && !READY.

Flags:
- CLEAR_FLAGS clears both flags. A flag-setting event in the same cycle takes priority and leaves the flag set.

Reset:
- Resets all outputs to 0, the FSM to IDLE, counters, shift registers and the synchroniser flops.
- Reset mid-frame discards partial data.
- After reset, no SAMPLE_VALID until one full ws_fall-to-ws_fall frame has been captured.

Latency:
- A frame's last right bit arrives at a BCLK rise. SAMPLE_VALID rises SYNC_STAGES+2 CLK cycles after that BCLK rise at the pins, counted from the first CLK that samples it high.

Test Plan:
1. CLK 50 MHz, BCLK 3.072 MHz, 32-bit slots, ENABLE=1, READY=1. Mic1 L=0xA5C3 R=0x1234, mic4 L=0x8001 R=0x7FFE, others 0 -> first frame after the ALIGN ws_fall gives SAMPLE_DATA mic1=0xA5C31234, mic4=0x80017FFE. VALID is a 1-cycle pulse, flags stay 0.
2. Start mid-frame: release RESET while WS=1 with bits streaming -> the partial frame is discarded, and the first VALID carries the next complete frame with exact values.
3. READY=0 for 3 frames (F1,F2,F3), then 1 -> SAMPLE_DATA holds F1, OVERRUN=1 after F2 arrives, and F2 and F3 are never presented. CLEAR_FLAGS -> OVERRUN=0.
4. 12-bit slots (WS toggles every 12 BCLK), DATA_BITS=16, L=0xABC -> left field=0xABC0, SHORT_FRAME=1.
5. Drop ENABLE during the LEFT slot of frame N -> frame N is still committed and no later VALID occurs. Reassert ENABLE -> capture resumes after the next ws_fall.
6. Assert RESET for 1 cycle during RIGHT slot -> all outputs 0 next cycle, no corrupt frame emitted, and normal capture resumes on the following full frame.
